// File: rtl/sw_display_feeder_pkg.sv
// Shared widths and helpers for the switch-to-display feeder and its debouncer.
package sw_display_feeder_pkg;

  localparam int DISP_DIGITS      = 8;
  localparam int DISP_W           = DISP_DIGITS * 4;
  localparam int SW_W             = 8;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  // Newest byte enters at the low digits; the top byte falls off.
  function automatic logic [DISP_W-1:0] shift_in(input logic [DISP_W-1:0] hist,
                                                 input logic [SW_W-1:0]   val);
    return {hist[DISP_W-SW_W-1:0], val};
  endfunction

endpackage

// File: rtl/sw_display_feeder_debouncer.sv
// Two-flop synchroniser plus whole-vector debouncer; pulses accept once per new settled value.
module sw_debouncer
  import sw_display_feeder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] cand,
  output logic [SW_W-1:0] stab,
  output logic            accept
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sw_p0;
  logic [SW_W-1:0]  sw_p1;
  logic [CNT_W-1:0] cnt;

  // Stable cand that differs from the last accepted value fires exactly once.
  always_comb begin
    accept = (sw_p1 == cand) && (cnt == CNT_MAX) && (cand != stab);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
      cand  <= '0;
      cnt   <= '0;
      stab  <= '0;
    end else begin
      // stage p0/p1: metastability filter on the raw switches
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
      // debounce stage: any movement restarts the hold count
      if (sw_p1 != cand) begin
        cand <= sw_p1;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        stab <= cand;
      end
    end
  end

endmodule

// File: rtl/sw_display_feeder.sv
// Builds the 32-bit scanner word from debounced switch values: 4-byte history, newest low.
module sw_display_feeder
  import sw_display_feeder_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [DISP_W-1:0] INIT_VALUE      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic              clear,
  output logic [DISP_W-1:0] output_data,
  output logic              upd,
  output logic [7:0]        change_cnt
);

  logic [SW_W-1:0] cand;
  logic [SW_W-1:0] stab;
  logic            accept;

  sw_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .cand  (cand),
    .stab  (stab),
    .accept(accept)
  );

  // Clear only touches the history side; the debouncer keeps consuming values,
  // so a value accepted during clear is dropped rather than replayed later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      output_data <= INIT_VALUE;
      change_cnt  <= '0;
      upd         <= 1'b0;
    end else if (clear) begin
      output_data <= INIT_VALUE;
      change_cnt  <= '0;
      upd         <= 1'b0;
    end else begin
      upd <= accept;
      if (accept) begin
        output_data <= shift_in(output_data, cand);
        change_cnt  <= change_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sw_display_feeder.sv
// Directed bench for sw_display_feeder with DEBOUNCE_CYCLES=4 (accept on 7th edge after a change).
module tb_sw_display_feeder;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic        clk;
  logic        rst;
  logic [7:0]  sw;
  logic        clear;
  logic [31:0] output_data;
  logic        upd;
  logic [7:0]  change_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int p_snap;

  sw_display_feeder #(
    .DEBOUNCE_CYCLES(D),
    .INIT_VALUE     (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .clear      (clear),
    .output_data(output_data),
    .upd        (upd),
    .change_cnt (change_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (upd === 1'b1) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a new value and step to its accept edge.
  task automatic settle(input logic [7:0] v);
    sw = v;
    repeat (LAT) tick();
  endtask

  initial begin
    rst   = 1'b0;
    clear = 1'b0;
    sw    = 8'hF0;
    repeat (2) tick();
    check("reset_data", output_data, 32'h0);
    check("reset_upd", {31'd0, upd}, 32'd0);
    check("reset_cnt", {24'd0, change_cnt}, 32'd0);

    // Power-up accept
    rst = 1'b1;
    repeat (LAT - 1) tick();
    check("pu_early_upd", {31'd0, upd}, 32'd0);
    check("pu_early_data", output_data, 32'h0);
    tick();
    check("pu_upd", {31'd0, upd}, 32'd1);
    check("pu_data", output_data, 32'h0000_00F0);
    check("pu_cnt", {24'd0, change_cnt}, 32'd1);
    tick();
    check("pu_upd_drop", {31'd0, upd}, 32'd0);
    repeat (10) tick();
    check("pu_one_pulse", pulses, 32'd1);

    // History shifting
    p_snap = pulses;
    settle(8'h55);
    check("hist1_upd", {31'd0, upd}, 32'd1);
    check("hist1_data", output_data, 32'h0000_F055);
    settle(8'hFF);
    check("hist2_data", output_data, 32'h00F0_55FF);
    check("hist2_cnt", {24'd0, change_cnt}, 32'd3);
    repeat (10) tick();
    check("hist_pulses", pulses - p_snap, 32'd2);

    // Glitch to 0xAA for two cycles
    p_snap = pulses;
    sw = 8'hAA;
    repeat (2) tick();
    sw = 8'hFF;
    repeat (20) tick();
    check("glitch_pulses", pulses - p_snap, 32'd0);
    check("glitch_data", output_data, 32'h00F0_55FF);
    check("glitch_cnt", {24'd0, change_cnt}, 32'd3);

    // Shift-out of oldest bytes
    settle(8'h11);
    settle(8'h22);
    settle(8'h33);
    settle(8'h44);
    check("wrap_data", output_data, 32'h1122_3344);
    check("wrap_cnt", {24'd0, change_cnt}, 32'd7);

    // Counter wrap: clear, 255 accepts, then one more
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_data", output_data, 32'h0);
    check("clr_cnt", {24'd0, change_cnt}, 32'd0);
    tick();
    p_snap = pulses;
    for (int i = 0; i < 255; i++) begin
      settle(i[0] ? 8'h02 : 8'h01);
    end
    check("pre_cnt", {24'd0, change_cnt}, 32'd255);
    settle(8'h99);
    check("cwrap_cnt", {24'd0, change_cnt}, 32'd0);
    check("cwrap_upd", {31'd0, upd}, 32'd1);
    check("cwrap_data", output_data, 32'h0102_0199);
    repeat (3) tick();
    check("cwrap_pulses", pulses - p_snap, 32'd256);

    // Clear on the accept edge
    sw = 8'h66;
    repeat (LAT - 1) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("cva_data", output_data, 32'h0);
    check("cva_cnt", {24'd0, change_cnt}, 32'd0);
    check("cva_upd", {31'd0, upd}, 32'd0);
    p_snap = pulses;
    repeat (20) tick();
    check("cva_hold_pulses", pulses - p_snap, 32'd0);
    check("cva_hold_data", output_data, 32'h0);

    // Reset in the middle of a debounce window
    settle(8'h12);
    check("pre_rst_data", output_data, 32'h0000_0012);
    sw = 8'h77;
    repeat (5) tick();
    p_snap = pulses;
    rst = 1'b0;
    tick();
    check("mid_rst_data", output_data, 32'h0);
    check("mid_rst_cnt", {24'd0, change_cnt}, 32'd0);
    check("mid_rst_upd", {31'd0, upd}, 32'd0);
    rst = 1'b1;
    repeat (LAT - 1) tick();
    check("post_rst_early_upd", {31'd0, upd}, 32'd0);
    check("post_rst_early_pulses", pulses - p_snap, 32'd0);
    tick();
    check("post_rst_upd", {31'd0, upd}, 32'd1);
    check("post_rst_data", output_data, 32'h0000_0077);
    check("post_rst_cnt", {24'd0, change_cnt}, 32'd1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
